// File: rtl/eu_operand_collector.sv
// eu_operand_collector: per-execution-unit operand collection stage.
//   Takes one instruction-queue entry. Immediate operands come straight from the entry.
//   Register operands are requested from the interconnect by source address.
//   When both operands are held, one operation is issued to the ALU with a valid/ready handshake.
// Ports: clk/reset (synchronous, active-high); i_instr/i_instr_valid/o_instr_ready (entry in);
//   o_opX_req_valid/o_opX_src_addr (request), i_opX_data/i_opX_data_valid (response),
//   o_opX_success (capture ack); o_alu_* / o_alu_valid / i_alu_ready (issue);
//   o_illegal (one-cycle pulse when a non-ALU entry is dropped).
// Optional feature macro: EU_OPCOL_FAST_ISSUE_EN. When defined, a new entry can be accepted in the
//   same cycle as the ALU handshake, so back-to-back immediate ops issue every cycle.
// Latency: an entry whose operands are both immediate issues one cycle after acceptance.
//   A register operand captured in cycle C issues in cycle C+1.

package pkg_dtypes;
   localparam int WORD_WIDTH = 32;
   localparam int LOG2_NUM_INSTRUCTIONS_PER_EXEC_TYPE = 4;

   typedef enum logic [1:0] {
      EXEC_UNIT_ALU     = 2'd0,
      EXEC_UNIT_CMP     = 2'd1,
      EXEC_UNIT_LDR_STR = 2'd2,
      EXEC_UNIT_BRANCH  = 2'd3
   } type_exec_type;

   typedef enum logic {
      IMM_OR_NONE = 1'b0,
      REG         = 1'b1
   } type_operand_mode;

   typedef struct packed {
      logic [2:0] euidx;
      logic [3:0] uid;
      logic [1:0] spec;
   } type_exec_unit_addr;

   localparam int EU_ADDR_WIDTH = $bits(type_exec_unit_addr);

   typedef struct packed {
      logic [WORD_WIDTH-1:0] data;
   } type_imm;

   typedef struct packed {
      logic [WORD_WIDTH-EU_ADDR_WIDTH-1:0] rsvd;
      type_exec_unit_addr                  src;
   } type_reg_ref;

   // An operand field holds either an immediate value or a source rename address.
   typedef union packed {
      type_imm     as_imm;
      type_reg_ref as_addr;
   } type_operand;

   typedef struct packed {
      type_exec_type                                 exec_type;
      logic [LOG2_NUM_INSTRUCTIONS_PER_EXEC_TYPE-1:0] specific_instr;
      type_exec_unit_addr                            opd;
      type_operand_mode                              op0m;
      type_operand                                   op0;
      type_operand_mode                              op1m;
      type_operand                                   op1;
   } type_iqueue_entry;
endpackage

module eu_operand_collector
   import pkg_dtypes::*;
#(
   parameter int DATA_WIDTH = WORD_WIDTH,
   parameter int ADDR_WIDTH = $bits(type_exec_unit_addr),
   parameter int OPC_WIDTH  = LOG2_NUM_INSTRUCTIONS_PER_EXEC_TYPE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  type_iqueue_entry      i_instr,
   input  logic                  i_instr_valid,
   output logic                  o_instr_ready,
   output logic                  o_op0_req_valid,
   output logic                  o_op1_req_valid,
   output logic [ADDR_WIDTH-1:0] o_op0_src_addr,
   output logic [ADDR_WIDTH-1:0] o_op1_src_addr,
   input  logic [DATA_WIDTH-1:0] i_op0_data,
   input  logic [DATA_WIDTH-1:0] i_op1_data,
   input  logic                  i_op0_data_valid,
   input  logic                  i_op1_data_valid,
   output logic                  o_op0_success,
   output logic                  o_op1_success,
   output logic [DATA_WIDTH-1:0] o_alu_op0_data,
   output logic [DATA_WIDTH-1:0] o_alu_op1_data,
   output logic [ADDR_WIDTH-1:0] o_alu_opd_addr,
   output logic [OPC_WIDTH-1:0]  o_alu_opcode,
   output logic                  o_alu_cmp,
   output logic                  o_alu_valid,
   input  logic                  i_alu_ready,
   output logic                  o_illegal
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_ISSUE   = 2'd2
   } state_t;

   state_t                state_q,   state_d;
   logic                  pend0_q,   pend0_d;
   logic                  pend1_q,   pend1_d;
   logic [DATA_WIDTH-1:0] data0_q,   data0_d;
   logic [DATA_WIDTH-1:0] data1_q,   data1_d;
   logic [ADDR_WIDTH-1:0] src0_q,    src0_d;
   logic [ADDR_WIDTH-1:0] src1_q,    src1_d;
   logic [ADDR_WIDTH-1:0] opd_q,     opd_d;
   logic [OPC_WIDTH-1:0]  opc_q,     opc_d;
   logic                  cmp_q,     cmp_d;
   logic                  illegal_q, illegal_d;

   logic succ0, succ1, accept, non_alu;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pend0_q   <= 1'b0;
         pend1_q   <= 1'b0;
         data0_q   <= '0;
         data1_q   <= '0;
         src0_q    <= '0;
         src1_q    <= '0;
         opd_q     <= '0;
         opc_q     <= '0;
         cmp_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend0_q   <= pend0_d;
         pend1_q   <= pend1_d;
         data0_q   <= data0_d;
         data1_q   <= data1_d;
         src0_q    <= src0_d;
         src1_q    <= src1_d;
         opd_q     <= opd_d;
         opc_q     <= opc_d;
         cmp_q     <= cmp_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pend0_d       = pend0_q;
      pend1_d       = pend1_q;
      data0_d       = data0_q;
      data1_d       = data1_q;
      src0_d        = src0_q;
      src1_d        = src1_q;
      opd_d         = opd_q;
      opc_d         = opc_q;
      cmp_d         = cmp_q;
      illegal_d     = 1'b0;
      o_instr_ready = 1'b0;
      o_alu_valid   = 1'b0;
      succ0         = 1'b0;
      succ1         = 1'b0;

      case (state_q)
         S_IDLE: begin
            o_instr_ready = 1'b1;
         end
         S_COLLECT: begin
            // Pending flags are only ever set in COLLECT, so they double as "request up".
            succ0 = pend0_q & i_op0_data_valid;
            succ1 = pend1_q & i_op1_data_valid;
            if (succ0) begin
               data0_d = i_op0_data;
               pend0_d = 1'b0;
            end
            if (succ1) begin
               data1_d = i_op1_data;
               pend1_d = 1'b0;
            end
            if (!pend0_d && !pend1_d) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            o_alu_valid = 1'b1;
            if (i_alu_ready) begin
               state_d = S_IDLE;
            end
`ifdef EU_OPCOL_FAST_ISSUE_EN
            // The ALU slot frees up this cycle, so the next entry can be loaded straight away.
            o_instr_ready = i_alu_ready;
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      accept  = o_instr_ready & i_instr_valid;
      non_alu = (i_instr.exec_type == EXEC_UNIT_LDR_STR) ||
                (i_instr.exec_type == EXEC_UNIT_BRANCH);

      // Loading a new entry overrides the transition back to IDLE from the handshake above.
      if (accept) begin
         if (non_alu) begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
         end else begin
            pend0_d = (i_instr.op0m == REG);
            pend1_d = (i_instr.op1m == REG);
            data0_d = (i_instr.op0m == REG) ? '0 : DATA_WIDTH'(i_instr.op0.as_imm.data);
            data1_d = (i_instr.op1m == REG) ? '0 : DATA_WIDTH'(i_instr.op1.as_imm.data);
            src0_d  = (i_instr.op0m == REG) ? ADDR_WIDTH'(i_instr.op0.as_addr.src) : '0;
            src1_d  = (i_instr.op1m == REG) ? ADDR_WIDTH'(i_instr.op1.as_addr.src) : '0;
            opd_d   = ADDR_WIDTH'(i_instr.opd);
            opc_d   = OPC_WIDTH'(i_instr.specific_instr);
            cmp_d   = (i_instr.exec_type == EXEC_UNIT_CMP);
            state_d = (pend0_d || pend1_d) ? S_COLLECT : S_ISSUE;
         end
      end
   end

   assign o_op0_req_valid = pend0_q;
   assign o_op1_req_valid = pend1_q;
   assign o_op0_src_addr  = src0_q;
   assign o_op1_src_addr  = src1_q;
   assign o_op0_success   = succ0;
   assign o_op1_success   = succ1;
   assign o_alu_op0_data  = data0_q;
   assign o_alu_op1_data  = data1_q;
   assign o_alu_opd_addr  = opd_q;
   assign o_alu_opcode    = opc_q;
   assign o_alu_cmp       = cmp_q;
   assign o_illegal       = illegal_q;

endmodule

// File: tb/tb_eu_operand_collector.sv
// Directed bench for eu_operand_collector: immediate issue, register collection with a
// delayed response, simultaneous capture, ALU stall, illegal-entry drop, mid-collect reset,
// and back-to-back throughput in the build configuration selected by EU_OPCOL_FAST_ISSUE_EN.

module tb_eu_operand_collector;
    import pkg_dtypes::*;

`ifdef EU_OPCOL_FAST_ISSUE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clk;
    logic             reset;
    type_iqueue_entry i_instr;
    logic             i_instr_valid;
    logic             o_instr_ready;
    logic             o_op0_req_valid, o_op1_req_valid;
    logic [8:0]       o_op0_src_addr, o_op1_src_addr;
    logic [31:0]      i_op0_data, i_op1_data;
    logic             i_op0_data_valid, i_op1_data_valid;
    logic             o_op0_success, o_op1_success;
    logic [31:0]      o_alu_op0_data, o_alu_op1_data;
    logic [8:0]       o_alu_opd_addr;
    logic [3:0]       o_alu_opcode;
    logic             o_alu_cmp;
    logic             o_alu_valid;
    logic             i_alu_ready;
    logic             o_illegal;

    int checks = 0;
    int errors = 0;

    eu_operand_collector dut (
        .clk              (clk),
        .reset            (reset),
        .i_instr          (i_instr),
        .i_instr_valid    (i_instr_valid),
        .o_instr_ready    (o_instr_ready),
        .o_op0_req_valid  (o_op0_req_valid),
        .o_op1_req_valid  (o_op1_req_valid),
        .o_op0_src_addr   (o_op0_src_addr),
        .o_op1_src_addr   (o_op1_src_addr),
        .i_op0_data       (i_op0_data),
        .i_op1_data       (i_op1_data),
        .i_op0_data_valid (i_op0_data_valid),
        .i_op1_data_valid (i_op1_data_valid),
        .o_op0_success    (o_op0_success),
        .o_op1_success    (o_op1_success),
        .o_alu_op0_data   (o_alu_op0_data),
        .o_alu_op1_data   (o_alu_op1_data),
        .o_alu_opd_addr   (o_alu_opd_addr),
        .o_alu_opcode     (o_alu_opcode),
        .o_alu_cmp        (o_alu_cmp),
        .o_alu_valid      (o_alu_valid),
        .i_alu_ready      (i_alu_ready),
        .o_illegal        (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic type_operand imm(input logic [31:0] v);
        type_operand o;
        o.as_imm.data = v;
        return o;
    endfunction

    function automatic type_operand reg_op(input type_exec_unit_addr a);
        type_operand o;
        o = '0;
        o.as_addr.src = a;
        return o;
    endfunction

    function automatic type_iqueue_entry mk(input type_exec_type et, input logic [3:0] opc,
                                            input type_exec_unit_addr opd,
                                            input type_operand_mode m0, input type_operand o0,
                                            input type_operand_mode m1, input type_operand o1);
        type_iqueue_entry e;
        e.exec_type      = et;
        e.specific_instr = opc;
        e.opd            = opd;
        e.op0m           = m0;
        e.op0            = o0;
        e.op1m           = m1;
        e.op1            = o1;
        return e;
    endfunction

    type_exec_unit_addr opd1, addr_a, addr_b, addr_z;
    int                 idx, n;
    int                 cyc[4];
    logic               acc;

    initial begin
        opd1   = '{euidx: 3'd1, uid: 4'd2, spec: 2'd3};
        addr_a = '{euidx: 3'd2, uid: 4'd5, spec: 2'd1};
        addr_b = '{euidx: 3'd4, uid: 4'd9, spec: 2'd2};
        addr_z = '0;
        reset = 1'b1;
        i_instr = '0;
        i_instr_valid = 1'b0;
        i_op0_data = '0;
        i_op1_data = '0;
        i_op0_data_valid = 1'b0;
        i_op1_data_valid = 1'b0;
        i_alu_ready = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_instr_ready", o_instr_ready === 1'b1, o_instr_ready, 1);
        chk("rst_alu_valid", o_alu_valid === 1'b0, o_alu_valid, 0);
        chk("rst_req0", o_op0_req_valid === 1'b0, o_op0_req_valid, 0);
        chk("rst_req1", o_op1_req_valid === 1'b0, o_op1_req_valid, 0);
        chk("rst_illegal", o_illegal === 1'b0, o_illegal, 0);
        chk("rst_alu_op0", o_alu_op0_data === 32'd0, o_alu_op0_data, 0);
        chk("rst_opd", o_alu_opd_addr === 9'd0, o_alu_opd_addr, 0);
        reset = 1'b0;
        tick();

        // ADD, both immediate: issue one cycle after acceptance
        i_alu_ready = 1'b1;
        i_instr = mk(EXEC_UNIT_ALU, 4'd4, opd1, IMM_OR_NONE, imm(32'd5), IMM_OR_NONE, imm(32'd7));
        i_instr_valid = 1'b1;
        #1;
        chk("add_instr_ready", o_instr_ready === 1'b1, o_instr_ready, 1);
        chk("add_req0_accept", o_op0_req_valid === 1'b0, o_op0_req_valid, 0);
        tick();
        i_instr_valid = 1'b0;
        #1;
        chk("add_valid", o_alu_valid === 1'b1, o_alu_valid, 1);
        chk("add_op0", o_alu_op0_data === 32'd5, o_alu_op0_data, 5);
        chk("add_op1", o_alu_op1_data === 32'd7, o_alu_op1_data, 7);
        chk("add_opcode", o_alu_opcode === 4'd4, o_alu_opcode, 4);
        chk("add_cmp", o_alu_cmp === 1'b0, o_alu_cmp, 0);
        chk("add_opd", o_alu_opd_addr === opd1, o_alu_opd_addr, opd1);
        chk("add_req0", o_op0_req_valid === 1'b0, o_op0_req_valid, 0);
        chk("add_req1", o_op1_req_valid === 1'b0, o_op1_req_valid, 0);
        chk("add_ready_in_issue", o_instr_ready === FAST, o_instr_ready, FAST);
        tick();
        chk("add_valid_after", o_alu_valid === 1'b0, o_alu_valid, 0);
        chk("add_ready_after", o_instr_ready === 1'b1, o_instr_ready, 1);

        // SUB, op0 register (response three cycles after request), op1 immediate
        i_instr = mk(EXEC_UNIT_ALU, 4'd5, opd1, REG, reg_op(addr_a), IMM_OR_NONE, imm(32'd9));
        i_instr_valid = 1'b1;
        #1;
        tick();
        i_instr_valid = 1'b0;
        #1;
        chk("sub_req0", o_op0_req_valid === 1'b1, o_op0_req_valid, 1);
        chk("sub_src0", o_op0_src_addr === addr_a, o_op0_src_addr, addr_a);
        chk("sub_req1", o_op1_req_valid === 1'b0, o_op1_req_valid, 0);
        chk("sub_succ0_early", o_op0_success === 1'b0, o_op0_success, 0);
        chk("sub_instr_ready", o_instr_ready === 1'b0, o_instr_ready, 0);
        tick();
        i_op1_data = 32'hDEAD;
        i_op1_data_valid = 1'b1;
        #1;
        chk("sub_stray_succ1", o_op1_success === 1'b0, o_op1_success, 0);
        chk("sub_src0_hold", o_op0_src_addr === addr_a, o_op0_src_addr, addr_a);
        tick();
        i_op1_data_valid = 1'b0;
        #1;
        chk("sub_valid_wait", o_alu_valid === 1'b0, o_alu_valid, 0);
        tick();
        i_op0_data = 32'h1234;
        i_op0_data_valid = 1'b1;
        #1;
        chk("sub_succ0", o_op0_success === 1'b1, o_op0_success, 1);
        chk("sub_valid_capture", o_alu_valid === 1'b0, o_alu_valid, 0);
        tick();
        i_op0_data_valid = 1'b0;
        #1;
        chk("sub_succ0_once", o_op0_success === 1'b0, o_op0_success, 0);
        chk("sub_req0_down", o_op0_req_valid === 1'b0, o_op0_req_valid, 0);
        chk("sub_valid", o_alu_valid === 1'b1, o_alu_valid, 1);
        chk("sub_op0", o_alu_op0_data === 32'h1234, o_alu_op0_data, 32'h1234);
        chk("sub_op1", o_alu_op1_data === 32'd9, o_alu_op1_data, 9);
        chk("sub_opcode", o_alu_opcode === 4'd5, o_alu_opcode, 5);
        tick();
        chk("sub_done", o_alu_valid === 1'b0, o_alu_valid, 0);

        // Both register, same source address, captured in the same cycle
        i_instr = mk(EXEC_UNIT_ALU, 4'd1, opd1, REG, reg_op(addr_b), REG, reg_op(addr_b));
        i_instr_valid = 1'b1;
        #1;
        tick();
        i_instr_valid = 1'b0;
        #1;
        chk("both_req0", o_op0_req_valid === 1'b1, o_op0_req_valid, 1);
        chk("both_req1", o_op1_req_valid === 1'b1, o_op1_req_valid, 1);
        chk("both_src1", o_op1_src_addr === addr_b, o_op1_src_addr, addr_b);
        tick();
        i_op0_data = 32'hAAAA0001;
        i_op1_data = 32'h55550002;
        i_op0_data_valid = 1'b1;
        i_op1_data_valid = 1'b1;
        #1;
        chk("both_succ0", o_op0_success === 1'b1, o_op0_success, 1);
        chk("both_succ1", o_op1_success === 1'b1, o_op1_success, 1);
        chk("both_valid_capture", o_alu_valid === 1'b0, o_alu_valid, 0);
        tick();
        i_op0_data_valid = 1'b0;
        i_op1_data_valid = 1'b0;
        #1;
        chk("both_valid", o_alu_valid === 1'b1, o_alu_valid, 1);
        chk("both_op0", o_alu_op0_data === 32'hAAAA0001, o_alu_op0_data, 32'hAAAA0001);
        chk("both_op1", o_alu_op1_data === 32'h55550002, o_alu_op1_data, 32'h55550002);
        chk("both_succ0_after", o_op0_success === 1'b0, o_op0_success, 0);
        tick();
        chk("both_single_issue", o_alu_valid === 1'b0, o_alu_valid, 0);

        // CMP held off by the ALU for four cycles
        i_alu_ready = 1'b0;
        i_instr = mk(EXEC_UNIT_CMP, 4'd2, opd1, IMM_OR_NONE, imm(32'd3), IMM_OR_NONE, imm(32'd8));
        i_instr_valid = 1'b1;
        #1;
        tick();
        i_instr_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("cmp_stall_valid", o_alu_valid === 1'b1, o_alu_valid, 1);
            chk("cmp_stall_op0", o_alu_op0_data === 32'd3, o_alu_op0_data, 3);
            chk("cmp_stall_op1", o_alu_op1_data === 32'd8, o_alu_op1_data, 8);
            chk("cmp_stall_cmp", o_alu_cmp === 1'b1, o_alu_cmp, 1);
            chk("cmp_stall_ready", o_instr_ready === 1'b0, o_instr_ready, 0);
            tick();
        end
        i_alu_ready = 1'b1;
        #1;
        chk("cmp_hs_valid", o_alu_valid === 1'b1, o_alu_valid, 1);
        chk("cmp_hs_ready", o_instr_ready === FAST, o_instr_ready, FAST);
        tick();
        chk("cmp_after", o_alu_valid === 1'b0, o_alu_valid, 0);

        // BRANCH entry is accepted and dropped with a single illegal pulse
        i_instr = mk(EXEC_UNIT_BRANCH, 4'd0, opd1, IMM_OR_NONE, imm(32'd1), IMM_OR_NONE, imm(32'd2));
        i_instr_valid = 1'b1;
        #1;
        chk("br_ready", o_instr_ready === 1'b1, o_instr_ready, 1);
        tick();
        i_instr_valid = 1'b0;
        #1;
        chk("br_illegal", o_illegal === 1'b1, o_illegal, 1);
        chk("br_valid", o_alu_valid === 1'b0, o_alu_valid, 0);
        chk("br_ready_after", o_instr_ready === 1'b1, o_instr_ready, 1);
        chk("br_req0", o_op0_req_valid === 1'b0, o_op0_req_valid, 0);
        tick();
        chk("br_illegal_once", o_illegal === 1'b0, o_illegal, 0);
        chk("br_no_issue", o_alu_valid === 1'b0, o_alu_valid, 0);

        // Reset in the middle of collection
        i_instr = mk(EXEC_UNIT_ALU, 4'd3, opd1, REG, reg_op(addr_a), REG, reg_op(addr_b));
        i_instr_valid = 1'b1;
        #1;
        tick();
        i_instr_valid = 1'b0;
        #1;
        chk("rc_req0", o_op0_req_valid === 1'b1, o_op0_req_valid, 1);
        reset = 1'b1;
        i_op0_data_valid = 1'b1;
        tick();
        chk("rc_instr_ready", o_instr_ready === 1'b1, o_instr_ready, 1);
        chk("rc_req0", o_op0_req_valid === 1'b0, o_op0_req_valid, 0);
        chk("rc_req1", o_op1_req_valid === 1'b0, o_op1_req_valid, 0);
        chk("rc_src0", o_op0_src_addr === addr_z, o_op0_src_addr, addr_z);
        chk("rc_succ0", o_op0_success === 1'b0, o_op0_success, 0);
        chk("rc_alu_valid", o_alu_valid === 1'b0, o_alu_valid, 0);
        chk("rc_alu_op0", o_alu_op0_data === 32'd0, o_alu_op0_data, 0);
        chk("rc_opcode", o_alu_opcode === 4'd0, o_alu_opcode, 0);
        reset = 1'b0;
        i_op0_data_valid = 1'b0;
        i_instr = mk(EXEC_UNIT_ALU, 4'd6, opd1, IMM_OR_NONE, imm(32'd11), IMM_OR_NONE, imm(32'd22));
        i_instr_valid = 1'b1;
        #1;
        tick();
        i_instr_valid = 1'b0;
        #1;
        chk("post_rst_valid", o_alu_valid === 1'b1, o_alu_valid, 1);
        chk("post_rst_op0", o_alu_op0_data === 32'd11, o_alu_op0_data, 11);
        chk("post_rst_op1", o_alu_op1_data === 32'd22, o_alu_op1_data, 22);
        chk("post_rst_opcode", o_alu_opcode === 4'd6, o_alu_opcode, 6);
        tick();

        // Four back-to-back immediate entries with the ALU always ready
        idx = 0;
        n = 0;
        for (int k = 0; k < 4; k++) cyc[k] = 0;
        for (int c = 0; c < 20; c++) begin
            i_instr_valid = (idx < 4);
            i_instr = mk(EXEC_UNIT_ALU, 4'd7, opd1, IMM_OR_NONE, imm(32'(16 + idx)),
                         IMM_OR_NONE, imm(32'(idx)));
            #1;
            if (o_alu_valid) begin
                chk("b2b_op0", o_alu_op0_data === 32'(16 + n), o_alu_op0_data, 16 + n);
                chk("b2b_op1", o_alu_op1_data === 32'(n), o_alu_op1_data, n);
                if (n < 4) cyc[n] = c;
                n++;
            end
            acc = o_instr_ready & i_instr_valid;
            tick();
            if (acc) idx++;
        end
        i_instr_valid = 1'b0;
        chk("b2b_count", n === 4, n, 4);
        for (int k = 1; k < 4; k++) begin
            if (k < n) chk("b2b_gap", (cyc[k] - cyc[k-1]) === (FAST ? 1 : 2),
                           cyc[k] - cyc[k-1], FAST ? 1 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eu_operand_collector.md
# eu_operand_collector

Per-execution-unit operand collection stage between the instruction queue and the ALU. It accepts one `type_iqueue_entry` at a time and requests each register operand from the interconnect by source address. Immediate operands are taken directly from the entry. Once both operands are held, it issues a complete operation to the ALU input under a valid/ready handshake.

## Interface
Parameters (defaults from `pkg_dtypes` / `design_parameters.sv`):
- DATA_WIDTH, `WORD_WIDTH, operand data width
- ADDR_WIDTH, $bits(type_exec_unit_addr), rename address width
- OPC_WIDTH, `LOG2_NUM_INSTRUCTIONS_PER_EXEC_TYPE, width of specific_instr

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_instr  in  $bits(type_iqueue_entry)  entry from instruction queue
- i_instr_valid  in  1  entry valid
- o_instr_ready  out  1  collector can accept entry
- o_op0_req_valid / o_op1_req_valid  out  1  operand request to interconnect
- o_op0_src_addr / o_op1_src_addr  out  ADDR_WIDTH  requested source address
- i_op0_data / i_op1_data  in  DATA_WIDTH  data from interconnect
- i_op0_data_valid / i_op1_data_valid  in  1  interconnect data valid
- o_op0_success / o_op1_success  out  1  capture acknowledge to interconnect
- o_alu_op0_data / o_alu_op1_data  out  DATA_WIDTH  operands to ALU
- o_alu_opd_addr  out  ADDR_WIDTH  destination address
- o_alu_opcode  out  OPC_WIDTH  specific_instr
- o_alu_cmp  out  1  exec_type == EXEC_UNIT_CMP
- o_alu_valid  out  1  operation valid
- i_alu_ready  in  1  ALU accepts operation
- o_illegal  out  1  one-cycle pulse: non-ALU exec_type dropped

## Operation
- States:
  - IDLE: no entry held.
  - COLLECT: entry held, at least one REG operand outstanding.
  - ISSUE: both operands held, o_alu_valid high.
- IDLE:
  - o_instr_ready=1.
  - On i_instr_valid, latch the entry.
  - For each operand: if opXm==IMM_OR_NONE, hold its data as opX.as_imm.data and mark it captured; if REG, mark it pending.
  - exec_type LDR_STR or BRANCH: accept the entry, pulse o_illegal next cycle, stay IDLE.
  - Otherwise: go to COLLECT if any operand is pending, else ISSUE.
- COLLECT:
  - o_opX_req_valid = pending_X.
  - o_opX_src_addr = opX.as_addr, held stable while the request is up.
  - o_opX_success = pending_X & i_opX_data_valid (combinational).
  - On success, capture i_opX_data and clear pending_X.
  - When no operand remains pending after this cycle's captures, go to ISSUE next cycle.
  - Both operands may be captured in the same cycle.
- ISSUE:
  - o_alu_valid=1; all o_alu_* outputs are stable until handshake.
  - On i_alu_ready, go to IDLE (or see Configuration).
- Operands with the same src_addr are requested and captured independently.
- No requests are made for IMM operands; o_opX_success=0 whenever no request is up.
- Reset (including mid-COLLECT/ISSUE): entry discarded, state IDLE.

## Timing
- Reset values: o_instr_ready=1; all other outputs 0.
- Entry accepted at cycle T with both operands IMM: o_alu_valid at T+1.
- REG operand: requested from T+1; data captured at cycle C gives o_alu_valid at C+1.
- Data presented with i_opX_data_valid while no request is up is ignored, with no success.
- o_alu_valid is held until i_alu_ready; no operation is ever dropped or duplicated.

## Configuration
- `EU_OPCOL_FAST_ISSUE_EN` defined:
  - in ISSUE, o_instr_ready = i_alu_ready;
  - a new entry is accepted in the handshake cycle, with no bubble;
  - back-to-back IMM/IMM entries issue every cycle.
- Undefined:
  - o_instr_ready=0 outside IDLE;
  - at least one idle cycle between successive issues (IMM/IMM throughput 1 per 2 cycles).

## Test plan
- ADD (4), op0 IMM 5, op1 IMM 7, opd {euidx 1, uid 2, spec 3}; i_alu_ready=1 -> o_alu_valid at T+1, data 5/7, opcode 4, cmp=0, no req_valid ever.
- SUB, op0 REG addr A, op1 IMM 9; interconnect returns 0x1234 three cycles after request -> o_op0_success for exactly 1 cycle, o_alu_valid next cycle with op0=0x1234, op1=9.
- Both operands REG, data_valid for both in the same cycle -> both success asserted together, single issue one cycle later.
- CMP with i_alu_ready low for 4 cycles -> outputs stable for 4 cycles, o_instr_ready low (both configs), issue on ready; o_alu_cmp=1.
- exec_type BRANCH entry -> accepted, o_illegal pulses once, no ALU issue; reset asserted mid-COLLECT -> all outputs 0, next entry processed normally.
- 4 back-to-back IMM/IMM entries, ready always high -> issues in 4 consecutive cycles with `EU_OPCOL_FAST_ISSUE_EN`, every other cycle without.
